// File: rtl/buffer_pkg.sv
// Shared types and default widths for the ping-pong buffer controller.
package buffer_pkg;

  typedef enum logic [1:0] {
    RENDER    = 2'd0,
    WAIT_SWAP = 2'd1,
    SWAP      = 2'd2
  } state_e;

  localparam int ADDR_W_DEF    = 10;
  localparam int DATA_W_DEF    = 12;
  localparam int RAM_DEPTH_DEF = 1024;

endpackage

// File: rtl/buffer_ctrl.sv
// Arbitrates the shared ping-pong buffer port between renderer and scanout,
// and swaps front/back buffers at vsync once a complete frame is written.
//
// state     | meaning
// ----------+---------------------------------------------------------
// RENDER    | accepting writes into the back buffer
// WAIT_SWAP | frame complete, writes stalled, waiting for vsync
// SWAP      | swap pending; fires on the first cycle without a read
module buffer_ctrl
  import buffer_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int RAM_DEPTH = RAM_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              vsync,
  output logic              buf_en,
  output logic              buf_w_en,
  output logic              buf_swap_en,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [DATA_W-1:0] buf_din,
  input  logic [DATA_W-1:0] buf_dout,
  output logic              front_sel,
  output logic [7:0]        swap_cnt,
  output logic [7:0]        late_cnt,
  output logic              oob_err
);

  // One extra bit so a depth equal to 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(RAM_DEPTH);

  state_e state, state_nx;
  logic   wr_hs;
  logic   wr_in_range;
  logic   swap_fire;
  logic   late_inc;

  assign wr_in_range = {1'b0, wr_addr} < DEPTH_L;
  assign wr_ready    = !rst && (state == RENDER) && !rd_req;
  assign wr_hs       = wr_valid && wr_ready;
  assign swap_fire   = !rst && (state == SWAP) && !rd_req;
  assign late_inc    = (state == RENDER) && vsync;
  assign rd_data     = rd_valid ? buf_dout : '0;

  always_comb begin
    buf_en      = 1'b0;
    buf_w_en    = 1'b0;
    buf_swap_en = 1'b0;
    buf_addr    = '0;
    buf_din     = '0;
    state_nx    = state;

    if (!rst) begin
      if (rd_req) begin
        buf_en   = 1'b1;
        buf_addr = rd_addr;
      end else if (wr_hs) begin
        // Out-of-range writes still handshake but never reach the RAM.
        buf_en   = wr_in_range;
        buf_w_en = wr_in_range;
        buf_addr = wr_addr;
        buf_din  = wr_data;
      end else if (swap_fire) begin
        buf_en      = 1'b1;
        buf_swap_en = 1'b1;
      end

      unique case (state)
        RENDER:    if (wr_hs && wr_last) state_nx = WAIT_SWAP;
        WAIT_SWAP: if (vsync)            state_nx = SWAP;
        SWAP:      if (!rd_req)          state_nx = RENDER;
        default:                         state_nx = RENDER;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RENDER;
      front_sel <= 1'b0;
      swap_cnt  <= 8'd0;
      late_cnt  <= 8'd0;
      oob_err   <= 1'b0;
      rd_valid  <= 1'b0;
    end else begin
      state    <= state_nx;
      rd_valid <= rd_req;
      if (swap_fire) begin
        front_sel <= ~front_sel;
        swap_cnt  <= swap_cnt + 8'd1;
      end
      if (late_inc && (late_cnt != 8'hFF)) late_cnt <= late_cnt + 8'd1;
      if (wr_hs && !wr_in_range) oob_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_buffer_ctrl.sv
// Bench for buffer_ctrl: directed scenarios plus random traffic, checked
// cycle by cycle against a frame-level behavioural model.
module tb_buffer_ctrl;

  localparam int AW    = 10;
  localparam int DW    = 12;
  localparam int DEPTH = 1000;

  logic          clk, rst;
  logic          wr_valid, wr_ready, wr_last;
  logic [AW-1:0] wr_addr, rd_addr, buf_addr;
  logic [DW-1:0] wr_data, rd_data, buf_din, buf_dout;
  logic          rd_req, rd_valid, vsync;
  logic          buf_en, buf_w_en, buf_swap_en;
  logic          front_sel, oob_err;
  logic [7:0]    swap_cnt, late_cnt;

  buffer_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RAM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_last(wr_last),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .vsync(vsync),
    .buf_en(buf_en), .buf_w_en(buf_w_en), .buf_swap_en(buf_swap_en),
    .buf_addr(buf_addr), .buf_din(buf_din), .buf_dout(buf_dout),
    .front_sel(front_sel), .swap_cnt(swap_cnt), .late_cnt(late_cnt),
    .oob_err(oob_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ping-pong buffer stand-in, driven only by the DUT's buf_* port.
  logic [DW-1:0] bmem [2][1024];
  logic          b_front;
  always @(posedge clk) begin
    if (rst) begin
      b_front <= 1'b0;
      for (int i = 0; i < 1024; i++) begin
        bmem[0][i] <= '0;
        bmem[1][i] <= '0;
      end
    end else if (buf_en) begin
      if (buf_swap_en)   b_front <= ~b_front;
      else if (buf_w_en) bmem[~b_front][buf_addr] <= buf_din;
      else               buf_dout <= bmem[b_front][buf_addr];
    end
  end

  int n_vec = 0;
  int n_err = 0;
  int swap_pulses = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: frame phase (0 rendering, 1 frame done, 2 swap owed).
  int            m_phase = 0;
  logic          m_front = 1'b0;
  logic [7:0]    m_swaps = 8'd0;
  int            m_late  = 0;
  logic          m_oob   = 1'b0;
  logic          m_pend  = 1'b0;
  logic [DW-1:0] m_pdata = '0;
  logic [DW-1:0] rmem [2][1024];

  task automatic step();
    logic e_ready, e_en, e_we, e_sw, hs, inr;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    #3;
    chk("rd_valid", rd_valid, m_pend);
    chk("rd_data", rd_data, m_pend ? m_pdata : '0);
    chk("front_sel", front_sel, m_front);
    chk("swap_cnt", swap_cnt, m_swaps);
    chk("late_cnt", late_cnt, m_late);
    chk("oob_err", oob_err, m_oob);
    if (buf_swap_en) swap_pulses++;

    e_ready = 0; e_en = 0; e_we = 0; e_sw = 0; e_addr = '0; e_din = '0;
    hs  = 0;
    inr = int'(wr_addr) < DEPTH;
    if (!rst) begin
      e_ready = (m_phase == 0) && !rd_req;
      hs = wr_valid && e_ready;
      if (rd_req) begin
        e_en = 1; e_addr = rd_addr;
      end else if (hs) begin
        e_en = inr; e_we = inr; e_addr = wr_addr; e_din = wr_data;
      end else if (m_phase == 2) begin
        e_en = 1; e_sw = 1;
      end
    end
    chk("wr_ready", wr_ready, e_ready);
    chk("buf_en", buf_en, e_en);
    chk("buf_w_en", buf_w_en, e_we);
    chk("buf_swap_en", buf_swap_en, e_sw);
    if (rst || e_en) chk("buf_addr", buf_addr, e_addr);
    if (rst || e_we) chk("buf_din", buf_din, e_din);

    if (rst) begin
      m_phase = 0; m_front = 0; m_swaps = 0; m_late = 0; m_oob = 0;
      m_pend = 0; m_pdata = '0;
      for (int i = 0; i < 1024; i++) begin
        rmem[0][i] = '0;
        rmem[1][i] = '0;
      end
    end else begin
      m_pend = rd_req;
      if (rd_req) m_pdata = rmem[m_front][rd_addr];
      if (hs && inr)  rmem[!m_front][wr_addr] = wr_data;
      if (hs && !inr) m_oob = 1;
      if (m_phase == 0 && vsync && m_late < 255) m_late++;
      case (m_phase)
        0: if (hs && wr_last) m_phase = 1;
        1: if (vsync) m_phase = 2;
        default: if (!rd_req) begin
          m_front = !m_front; m_swaps = m_swaps + 8'd1; m_phase = 0;
        end
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic wl, input logic rr, input logic [AW-1:0] ra,
                       input logic vs);
    wr_valid = wv; wr_addr = wa; wr_data = wd; wr_last = wl;
    rd_req = rr; rd_addr = ra; vsync = vs;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, '0, '0, 0, 0, '0, 0);
  endtask

  int base_late, base_swaps, base_pulses;

  initial begin
    rst = 1'b1;
    wr_valid = 0; wr_addr = '0; wr_data = '0; wr_last = 0;
    rd_req = 0; rd_addr = '0; vsync = 0; buf_dout = '0;
    @(posedge clk);
    #1;
    idle(2);
    rst = 1'b0;
    idle(1);

    // Write a 4-pixel frame, swap at vsync, read back from the new front.
    for (int i = 0; i < 4; i++)
      drive(1, AW'(i), DW'(12'hA00 + i), i == 3, 0, '0, 0);
    drive(0, '0, '0, 0, 0, '0, 1);
    idle(1);
    drive(0, '0, '0, 0, 1, AW'(2), 0);
    chk("t1_swap_cnt", swap_cnt, 1);
    chk("t1_front", front_sel, 1);
    chk("t1_rd_valid", rd_valid, 1);
    chk("t1_rd_data", rd_data, 12'hA02);
    idle(1);

    // Read priority over a pending write.
    for (int i = 0; i < 3; i++) drive(1, AW'(7), 12'h777, 0, 1, AW'(i), 0);
    drive(1, AW'(7), 12'h777, 0, 0, '0, 0);
    idle(1);

    // Two vsyncs with no frame ready.
    base_late = late_cnt; base_swaps = swap_cnt;
    drive(0, '0, '0, 0, 0, '0, 1);
    idle(1);
    drive(0, '0, '0, 0, 0, '0, 1);
    chk("t3_late", late_cnt - base_late, 2);
    chk("t3_swaps", swap_cnt - base_swaps, 0);

    // Swap deferred behind reads; vsync during deferral is not late.
    drive(1, AW'(9), 12'h999, 1, 0, '0, 0);
    base_late = late_cnt; base_pulses = swap_pulses;
    drive(0, '0, '0, 0, 1, AW'(1), 1);
    drive(0, '0, '0, 0, 1, AW'(2), 1);
    drive(0, '0, '0, 0, 1, AW'(3), 0);
    drive(0, '0, '0, 0, 0, '0, 0);
    idle(1);
    chk("t4_pulses", swap_pulses - base_pulses, 1);
    chk("t4_late", late_cnt - base_late, 0);

    // Out-of-range write is accepted but dropped, and flags sticky error.
    drive(1, AW'(1023), 12'hBAD, 0, 0, '0, 0);
    idle(3);
    chk("t5_oob", oob_err, 1);

    // Reset while waiting for swap: no swap on the next vsync.
    drive(1, AW'(5), 12'h555, 1, 0, '0, 0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    base_pulses = swap_pulses;
    drive(0, '0, '0, 0, 0, '0, 1);
    idle(2);
    chk("t6_front", front_sel, 0);
    chk("t6_pulses", swap_pulses - base_pulses, 0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 1),
            ($urandom_range(0, 15) == 0) ? AW'($urandom_range(1000, 1023))
                                         : AW'($urandom_range(0, 999)),
            DW'($urandom),
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 2) == 0,
            AW'($urandom_range(0, 999)),
            $urandom_range(0, 9) == 0);
    end
    rst = 1'b0;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/buffer_ctrl.md
# buffer_ctrl

Sequences the ping-pong `buffer` block between a frame renderer (writer) and a display scanout (reader). The buffer exposes one shared address port, so this block arbitrates it, giving the reader strict priority. It stalls the writer with a ready/valid handshake and issues the buffer swap at vertical sync, only once a full frame has been written. It sits between the renderer/scanout pair and the `buffer` instance in the display path.

## Interface
- `ADDR_W`, 10, address width (buffer `addr`)
- `DATA_W`, 12, pixel width (buffer `din`/`dout`)
- `RAM_DEPTH`, 1024, valid address count; addresses ≥ RAM_DEPTH are out of range
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `wr_valid`  in  1  writer request
- `wr_ready`  out  1  writer accepted this cycle
- `wr_addr`  in  ADDR_W  write address
- `wr_data`  in  DATA_W  write pixel
- `wr_last`  in  1  qualifies the final pixel of a frame
- `rd_req`  in  1  scanout read request
- `rd_addr`  in  ADDR_W  read address
- `rd_valid`  out  1  `rd_data` valid
- `rd_data`  out  DATA_W  read pixel
- `vsync`  in  1  one-cycle vertical sync pulse
- `buf_en`, `buf_w_en`, `buf_swap_en`  out  1  buffer controls
- `buf_addr`  out  ADDR_W  buffer address
- `buf_din`  out  DATA_W  buffer write data
- `buf_dout`  in  DATA_W  buffer read data
- `front_sel`  out  1  index of the displayed buffer; toggles on each swap
- `swap_cnt`  out  8  completed swaps, wraps at 255→0
- `late_cnt`  out  8  vsyncs with no frame ready; saturates at 255
- `oob_err`  out  1  sticky flag, set by an out-of-range write

## Operation
- States: RENDER, WAIT_SWAP, SWAP. Reset state is RENDER.
- Port arbitration, evaluated each cycle:
  - `rd_req`=1 has priority: `buf_en`=1, `buf_w_en`=0, `buf_addr`=`rd_addr`.
  - Otherwise, in RENDER with `wr_valid`=1, a write issues.
  - Otherwise the port is idle and `buf_en`=0.
- `wr_ready` = (state==RENDER) && !`rd_req`. It is combinational.
- A write handshake (`wr_valid` && `wr_ready`) drives `buf_en`=1, `buf_w_en`=1, `buf_addr`=`wr_addr`, `buf_din`=`wr_data`.
  - If `wr_addr` ≥ RAM_DEPTH, the handshake still completes but `buf_en` and `buf_w_en` stay 0, and `oob_err` is set.
- RENDER → WAIT_SWAP on a handshake with `wr_last`=1.
- RENDER with `vsync`=1 increments `late_cnt`. This holds even if `wr_last` completes in the same cycle.
- WAIT_SWAP → SWAP on `vsync`. Writes stall throughout WAIT_SWAP.
- SWAP:
  - With `rd_req`=0: drive `buf_en`=1, `buf_swap_en`=1, `buf_w_en`=0, toggle `front_sel`, increment `swap_cnt`, then go to RENDER.
  - With `rd_req`=1: serve the read and remain in SWAP.
- `vsync` in WAIT_SWAP while `rd_req`=1 still moves to SWAP.
- `vsync` in SWAP is ignored and is not counted as late.
- `buf_swap_en` and `buf_w_en` are never high in the same cycle.

## Timing
- `buf_*` outputs are combinational from state and requests. Buffer read latency is 1 cycle.
- `rd_req` at cycle N gives `rd_valid`=1 at N+1, with `rd_data`=`buf_dout`. When `rd_valid`=0, `rd_data` is 0.
- Write latency: data is in the back buffer at the clock edge that ends the handshake cycle.
- Swap is visible to reads issued from the cycle after SWAP onward.
- Reset values:
  - State RENDER; `front_sel`=0, `swap_cnt`=0, `late_cnt`=0, `oob_err`=0, `rd_valid`=0, `rd_data`=0.
  - While `rst`=1: all `buf_*`=0 and `wr_ready`=0.
- Reset asserted mid-frame or in SWAP: abandon the frame and perform no swap.
  - The next frame starts in RENDER. Back-buffer contents are undefined.

## Structure
- `buffer_pkg`: state enum (RENDER, WAIT_SWAP, SWAP) and the default width constants.
- No sub-module. Counters and the FSM are inline. The `buffer` instance lives in the parent.

## Test plan
- **Write then read.** Frame of 4 writes (addr 0..3, data 0xA00..0xA03, `wr_last` on addr 3), then `vsync`, then `rd_req` at addr 2.
  - Expect `swap_cnt`=1, `front_sel`=1, and 0xA02 at N+1 with `rd_valid`=1.
- **Read priority.** Hold `rd_req`=1 and `wr_valid`=1 for 3 cycles.
  - Expect `wr_ready`=0 and `buf_w_en`=0 throughout. The write completes in the first cycle after `rd_req` drops.
- **Late frame.** Pulse `vsync` twice during RENDER with no `wr_last`.
  - Expect `late_cnt`=2, `swap_cnt`=0, `front_sel` unchanged.
- **Swap deferral.** `vsync` in WAIT_SWAP with `rd_req` held for 2 more cycles.
  - Expect `buf_swap_en` to pulse exactly once, on the first cycle with `rd_req`=0.
  - `vsync` arriving during the deferral leaves `late_cnt` unchanged.
- **Out-of-range write.** `wr_addr`=1023 with RAM_DEPTH=1000.
  - Expect the handshake to complete, `buf_en`=0, `oob_err`=1 and held until `rst`.
- **Reset mid-frame.** Assert `rst` in WAIT_SWAP.
  - Expect RENDER, `front_sel`=0, and no `buf_swap_en` on the following `vsync`.
